// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared definitions for the pipelined RV32I core: datapath widths, the
//   bubble instruction word, the PC step, the next-PC source encoding and
//   the IF/ID register layout.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [ILEN-1:0] ins_t;

    // addi x0,x0,0
    localparam ins_t  NOP_INS = 32'h0000_0013;
    localparam addr_t PC_STEP = 32'd4;

    // Source of the next PC value, listed in priority order.
    typedef enum logic [1:0] {
        NPC_RESET,
        NPC_REDIRECT,
        NPC_HOLD,
        NPC_SEQ
    } npc_sel_e;

    // IF/ID pipeline register contents.
    typedef struct packed {
        ins_t  ins;
        addr_t pc;
        addr_t pc_plus4;
        logic  valid;
    } ifid_t;

    // Force an address onto a word boundary; misalignment is never trapped here.
    function automatic addr_t align_word(input addr_t a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if
//   Groups the fetch stage's bus signals: hazard-unit controls, the EX
//   redirect, the instruction-memory read port and the IF/ID outputs.
//   master: the fetch stage itself.
//   slave : the surrounding core (hazard unit, EX, memory, decode).
interface if_stage_if;
    import riscv_pkg::*;

    logic  stall;       // hold PC and IF/ID
    logic  flush;       // replace IF/ID with a bubble
    logic  pc_src;      // EX redirect select
    addr_t target;      // EX redirect address
    addr_t imem_addr;   // instruction-memory address (= current PC)
    ins_t  imem_rdata;  // combinational instruction word
    ins_t  ins_d;       // IF/ID instruction
    addr_t pc_d;        // IF/ID PC of ins_d
    addr_t pc_plus4_d;  // IF/ID pc_d + 4
    logic  valid_d;     // 1 = real instruction, 0 = bubble

    modport master (
        input  stall, flush, pc_src, target, imem_rdata,
        output imem_addr, ins_d, pc_d, pc_plus4_d, valid_d
    );

    modport slave (
        output stall, flush, pc_src, target, imem_rdata,
        input  imem_addr, ins_d, pc_d, pc_plus4_d, valid_d
    );

endinterface

// File: rtl/if_stage_pc_reg.sv
// pc_reg
//   Program-counter register with hold enable, redirect mux and synchronous
//   reset. Next-PC priority: rst, redirect, hold (en=0), sequential +4.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset, loads RESET_PC
//   en       : 0 holds the PC (stall); redirect overrides it
//   redirect : take the aligned target address
//   target   : redirect address, low two bits ignored
//   pc       : current PC
//   pc_plus4 : pc + 4, modulo 2^32
module pc_reg
    import riscv_pkg::*;
#(
    parameter addr_t RESET_PC = 32'h0000_0000
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  redirect,
    input  addr_t target,
    output addr_t pc,
    output addr_t pc_plus4
);

    addr_t    pc_q;
    addr_t    pc_next;
    npc_sel_e sel;

    // Wraps silently at the top of the address space.
    assign pc_plus4 = pc_q + PC_STEP;
    assign pc       = pc_q;

    always_comb begin
        sel = NPC_SEQ;
        if (rst) begin
            sel = NPC_RESET;
        end else if (redirect) begin
            sel = NPC_REDIRECT;
        end else if (!en) begin
            sel = NPC_HOLD;
        end
    end

    always_comb begin
        pc_next = pc_plus4;
        unique case (sel)
            NPC_RESET:    pc_next = RESET_PC;
            NPC_REDIRECT: pc_next = align_word(target);
            NPC_HOLD:     pc_next = pc_q;
            NPC_SEQ:      pc_next = pc_plus4;
            default:      pc_next = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        pc_q <= pc_next;
    end

endmodule

// File: rtl/if_stage.sv
// if_stage
//   Instruction-fetch stage and IF/ID pipeline register. Holds the PC,
//   presents it on the instruction-memory read port, and registers the
//   returned word with its PC and PC+4 for decode. Supports hazard-unit
//   stall (hold everything) and flush (insert a bubble).
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : if_stage_if.master
//         in : stall, flush, pc_src, target, imem_rdata
//         out: imem_addr, ins_d, pc_d, pc_plus4_d, valid_d
module if_stage
    import riscv_pkg::*;
#(
    parameter addr_t RESET_PC = 32'h0000_0000,
    parameter ins_t  NOP_INS  = riscv_pkg::NOP_INS
) (
    input  logic          clk,
    input  logic          rst,
    if_stage_if.master    bus
);

    addr_t pc_f;
    addr_t pc_f_plus4;
    ifid_t ifid_q;
    ifid_t ifid_next;

    // Redirect beats stall for the PC; the hazard unit pairs flush with it.
    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .en       (~bus.stall),
        .redirect (bus.pc_src),
        .target   (bus.target),
        .pc       (pc_f),
        .pc_plus4 (pc_f_plus4)
    );

    assign bus.imem_addr = pc_f;

    // IF/ID priority: rst/flush bubble, then stall hold, then load.
    always_comb begin
        ifid_next = ifid_q;
        if (rst || bus.flush) begin
            ifid_next.ins      = NOP_INS;
            ifid_next.pc       = '0;
            ifid_next.pc_plus4 = '0;
            ifid_next.valid    = 1'b0;
        end else if (!bus.stall) begin
            ifid_next.ins      = bus.imem_rdata;
            ifid_next.pc       = pc_f;
            ifid_next.pc_plus4 = pc_f_plus4;
            ifid_next.valid    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        ifid_q <= ifid_next;
    end

    assign bus.ins_d      = ifid_q.ins;
    assign bus.pc_d       = ifid_q.pc;
    assign bus.pc_plus4_d = ifid_q.pc_plus4;
    assign bus.valid_d    = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] salt;
    int          checks = 0;
    int          errors = 0;

    // Reference model state
    logic        m_init = 1'b0;
    logic [31:0] m_pc;
    logic [31:0] m_ins;
    logic [31:0] m_pcd;
    logic [31:0] m_p4;
    logic        m_valid;

    if_stage_if bus ();
    if_stage_if bus2 ();

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INS  (32'h0000_0013)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    if_stage #(
        .RESET_PC (32'hFFFF_FFFC),
        .NOP_INS  (32'h0000_0013)
    ) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    // Memory contents: word = address ^ salt.
    assign bus.imem_rdata  = bus.imem_addr ^ salt;
    assign bus2.imem_rdata = bus2.imem_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: applies the fetch rules to the inputs seen at each edge.
    always @(posedge clk) begin
        logic [31:0] word;
        word = m_pc ^ salt;
        if (rst) begin
            m_init  = 1'b1;
            m_pc    = 32'h0;
            m_ins   = 32'h13;
            m_pcd   = 32'h0;
            m_p4    = 32'h0;
            m_valid = 1'b0;
        end else begin
            if (bus.flush) begin
                m_ins = 32'h13; m_pcd = 32'h0; m_p4 = 32'h0; m_valid = 1'b0;
            end else if (!bus.stall) begin
                m_ins = word; m_pcd = m_pc; m_p4 = m_pc + 32'd4; m_valid = 1'b1;
            end
            if (bus.pc_src)
                m_pc = bus.target & 32'hFFFF_FFFC;
            else if (!bus.stall)
                m_pc = m_pc + 32'd4;
        end
    end

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_init) begin
            chk("imem_addr",  bus.imem_addr,        m_pc);
            chk("ins_d",      bus.ins_d,            m_ins);
            chk("pc_d",       bus.pc_d,             m_pcd);
            chk("pc_plus4_d", bus.pc_plus4_d,       m_p4);
            chk("valid_d",    {31'b0, bus.valid_d}, {31'b0, m_valid});
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic s, input logic f, input logic p, input logic [31:0] t);
        bus.stall  = s;
        bus.flush  = f;
        bus.pc_src = p;
        bus.target = t;
    endtask

    initial begin
        rst  = 1'b1;
        salt = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        bus2.stall = 1'b0; bus2.flush = 1'b0; bus2.pc_src = 1'b0; bus2.target = 32'h0;

        // Reset for two cycles
        @(negedge clk);
        cyc();
        cyc();
        chk("rst ins_d",      bus.ins_d,           32'h0000_0013);
        chk("rst valid_d",    {31'b0, bus.valid_d}, 32'h0);
        chk("rst imem_addr",  bus.imem_addr,       32'h0);
        chk("wrap rst addr",  bus2.imem_addr,      32'hFFFF_FFFC);

        // Free run
        rst = 1'b0;
        cyc();
        chk("run0 ins_d", bus.ins_d, 32'h0);
        chk("run0 p4",    bus.pc_plus4_d, 32'h4);
        chk("run0 valid", {31'b0, bus.valid_d}, 32'h1);
        chk("wrap addr1", bus2.imem_addr, 32'h0);
        chk("wrap pc_d",  bus2.pc_d, 32'hFFFF_FFFC);
        chk("wrap p4",    bus2.pc_plus4_d, 32'h0);
        chk("wrap ins_d", bus2.ins_d, 32'hFFFF_FFFC);
        cyc();
        chk("run1 ins_d", bus.ins_d, 32'h4);
        chk("run1 p4",    bus.pc_plus4_d, 32'h8);
        cyc();
        chk("run2 ins_d", bus.ins_d, 32'h8);
        chk("run2 p4",    bus.pc_plus4_d, 32'hC);
        cyc();
        chk("pre-stall addr", bus.imem_addr, 32'h10);

        // Stall three cycles at pc_f = 0x10
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall addr",  bus.imem_addr, 32'h10);
            chk("stall ins_d", bus.ins_d,     32'hC);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cyc();
        chk("resume addr",  bus.imem_addr, 32'h14);
        chk("resume ins_d", bus.ins_d,     32'h10);
        cyc(); cyc(); cyc();
        chk("pre-redir addr", bus.imem_addr, 32'h20);

        // Redirect with flush to misaligned target
        drive(1'b0, 1'b1, 1'b1, 32'h103);
        cyc();
        chk("redir addr",  bus.imem_addr, 32'h100);
        chk("redir ins_d", bus.ins_d,     32'h13);
        chk("redir valid", {31'b0, bus.valid_d}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cyc();
        chk("tgt pc_d",  bus.pc_d, 32'h100);
        chk("tgt valid", {31'b0, bus.valid_d}, 32'h1);

        // stall + flush + pc_src together
        drive(1'b1, 1'b1, 1'b1, 32'h200);
        cyc();
        chk("sfp addr",  bus.imem_addr, 32'h200);
        chk("sfp ins_d", bus.ins_d,     32'h13);
        chk("sfp valid", {31'b0, bus.valid_d}, 32'h0);

        // Reset during stall at pc_f = 0x40
        drive(1'b0, 1'b0, 1'b1, 32'h40);
        cyc();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        chk("stall40 addr", bus.imem_addr, 32'h40);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'h500);
        cyc();
        chk("midrst addr",  bus.imem_addr, 32'h0);
        chk("midrst valid", {31'b0, bus.valid_d}, 32'h0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);

        // Randomized phase, checked by the model every cycle
        for (int n = 0; n < 400; n++) begin
            logic p;
            logic [31:0] t;
            p = ($urandom_range(0, 99) < 15);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            bus.stall  = ($urandom_range(0, 99) < 25);
            bus.pc_src = p;
            bus.flush  = p ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
            bus.target = t;
            rst = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 19) == 0)
                salt = $urandom;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
